text_glyph_sequencer: RTL
=========================

Name: text_glyph_sequencer

Overview: Sequences the alphabet glyph lookup for VGA text mode. Per character cell it reads the character code from text RAM, strobes the glyph lookup, picks the glyph row for the current scanline, and serialises it MSB-first as one pixel per clock. It sits between the VGA timing generator and the pixel colour mux, and is the only driver of the glyph lookup's code/strobe inputs.

Parameters:
COLS, 80, character columns per text line
ROWS, 30, character rows per frame
GLYPH_H, 16, scanlines per glyph; glyph_rows carries GLYPH_H bytes
ADDR_W, 12, text RAM address width

Ports:
s  in  1  pixel clock, posedge
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse before the first line of a frame
line_start  in  1  one-cycle pulse, at least 8 cycles before the first de cycle of each active line
de  in  1  display enable, one pixel per cycle
char_rd  out  1  text RAM read strobe
char_addr  out  ADDR_W  text RAM address = char_row*COLS+col
char_data  in  8  character code, valid the cycle after char_rd
glyph_code  out  8  code to the glyph lookup
glyph_strobe  out  1  one-cycle lookup clock enable
glyph_rows  in  8*GLYPH_H  lookup results; row r at [8r+7:8r], valid the cycle after glyph_strobe
pixel  out  1  serial pixel
pixel_valid  out  1  registered copy of de
underrun  out  1  sticky: the shifter needed a byte that was not ready

Behaviour:
- Reset (async, rst_n=0): every output 0; FSM=IDLE; col, char_row, row_in_cell, bit_cnt, shift, next_bits, next_full, underrun all 0.
- Counters: col 0..COLS-1, char_row 0..ROWS-1, row_in_cell 0..GLYPH_H-1.
- frame_start clears char_row and row_in_cell, and aborts the FSM to IDLE.
- On each falling edge of de, row_in_cell increments. At GLYPH_H-1 it wraps to 0 and char_row increments. char_row wraps from ROWS-1 to 0.
- FSM states:
  - IDLE: on line_start, set col=0, clear next_full and bit_cnt, go to RD_CHAR.
  - RD_CHAR: char_rd=1 for one cycle; go to LOOKUP.
  - LOOKUP: glyph_code<=char_data, glyph_strobe=1 for one cycle; go to CAPTURE.
  - CAPTURE: next_bits<=glyph_rows[8*row_in_cell +: 8], next_full<=1; go to WAIT.
  - WAIT: once next_full==0, either col++ and go to RD_CHAR, or go to IDLE if col==COLS-1.
- Fetch latency: 3 cycles from RD_CHAR to next_full, which is under the 8-cycle cell budget.
- line_start while the FSM is not IDLE: abort and restart at col=0 in RD_CHAR on the next cycle.
- frame_start and line_start in the same cycle: the frame clear applies first, then line fetch starts for char_row 0, row 0.
- Shifter, on a de cycle:
  - If bit_cnt==0 and next_full: shift<=next_bits, clear next_full, pixel<=next_bits[7].
  - If bit_cnt==0 and !next_full: pixel<=0, underrun<=1.
  - Otherwise: pixel<=shift bit (7-bit_cnt).
  - bit_cnt increments mod 8.
- When de is low: pixel<=0 and bit_cnt<=0.
- pixel and pixel_valid lag de by 1 cycle.
- Clearing next_full and CAPTURE setting it in the same cycle: the set wins.
- underrun clears only on reset.

Optional Feature:
- Macro TEXT_GLYPH_CURSOR_EN.
- Defined: adds inputs cursor_col[6:0] and cursor_row[4:0], plus a 6-bit frame counter that increments on frame_start.
  - When the cell being shifted matches (cursor_col, cursor_row) and frame counter bit 5 = 1, pixels of that cell are inverted.
  - The cell match is latched with next_bits at CAPTURE time.
- Undefined: no extra ports and no inversion; pixel stream is unchanged.

Test Plan:
- Reset mid-line with de=1 and the FSM in LOOKUP -> all outputs 0 immediately; after release, nothing happens until line_start.
- frame_start, line_start, then 640 de cycles; char_data=0x41 everywhere; glyph_rows row0=0x18 -> char_addr 0..79 in order; pixel pattern 00011000 repeated 80 times; underrun=0.
- Scanline 17 of the frame (row_in_cell wraps 15->0) -> char_addr starts at 80; the row-0 byte is selected.
- line_start only 2 cycles before de -> first cell outputs 0 and underrun=1 sticks; later cells correct.
- line_start pulsed again at col=5 -> FSM restarts at char_addr = char_row*80+0; no glyph_strobe for the aborted column.
- With TEXT_GLYPH_CURSOR_EN, cursor (2,0), frame counter bit5=1, row byte 0x18 -> cell 2 outputs 11100111; bit5=0 -> 00011000.

Source files
------------

// File: rtl/text_glyph_sequencer_if.sv
// Glyph sequencer bus: VGA timing inputs, text RAM read port, glyph lookup port and pixel output.
interface text_glyph_sequencer_if #(
  parameter int ADDR_W  = 12,
  parameter int GLYPH_H = 16
);
  logic                   frame_start;
  logic                   line_start;
  logic                   de;
  logic                   char_rd;
  logic [ADDR_W-1:0]      char_addr;
  logic [7:0]             char_data;
  logic [7:0]             glyph_code;
  logic                   glyph_strobe;
  logic [8*GLYPH_H-1:0]   glyph_rows;
  logic                   pixel;
  logic                   pixel_valid;
  logic                   underrun;

  modport master (
    output frame_start, line_start, de, char_data, glyph_rows,
    input  char_rd, char_addr, glyph_code, glyph_strobe, pixel, pixel_valid, underrun
  );

  modport slave (
    input  frame_start, line_start, de, char_data, glyph_rows,
    output char_rd, char_addr, glyph_code, glyph_strobe, pixel, pixel_valid, underrun
  );
endinterface

// File: rtl/text_glyph_sequencer.sv
// VGA text-mode glyph sequencer: fetches char code and glyph row per cell, serialises MSB-first.
// Optional cursor inversion (blinking via frame counter bit 5) when TEXT_GLYPH_CURSOR_EN is defined.
//
// state   | meaning
// IDLE    | waiting for line_start
// RD_CHAR | text RAM read strobe for column col
// LOOKUP  | char_data presented to glyph lookup, strobe high
// CAPTURE | glyph row for row_in_cell loaded into next_bits
// WAIT    | holding next_bits until the shifter takes it
module text_glyph_sequencer #(
  parameter int COLS    = 80,
  parameter int ROWS    = 30,
  parameter int GLYPH_H = 16,
  parameter int ADDR_W  = 12
) (
  input logic s,
  input logic rst_n,
`ifdef TEXT_GLYPH_CURSOR_EN
  input logic [6:0] cursor_col,
  input logic [4:0] cursor_row,
`endif
  text_glyph_sequencer_if.slave bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int GW = $clog2(GLYPH_H);

  typedef enum logic [2:0] {IDLE, RD_CHAR, LOOKUP, CAPTURE, WAIT} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] col;
  logic [RW-1:0] char_row;
  logic [GW-1:0] row_in_cell;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift, next_bits, code_q;
  logic          next_full;
  logic          pixel_q, pixel_valid_q, underrun_q;
  logic          char_rd_c, strobe_c;
  logic          inv_next, inv_cur;

  always_ff @(posedge s or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      RD_CHAR: state_nxt = LOOKUP;
      LOOKUP:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = WAIT;
      WAIT:    if (!next_full) state_nxt = (col == CW'(COLS-1)) ? IDLE : RD_CHAR;
      default: state_nxt = IDLE;
    endcase
    // line_start wins over frame_start so a coincident pair starts row 0 immediately
    if (bus.line_start)       state_nxt = RD_CHAR;
    else if (bus.frame_start) state_nxt = IDLE;
  end

  always_comb begin
    char_rd_c = 1'b0;
    strobe_c  = 1'b0;
    case (state)
      RD_CHAR: char_rd_c = !bus.line_start;
      LOOKUP:  strobe_c  = !bus.line_start;
      default: ;
    endcase
  end

  assign bus.char_rd      = char_rd_c;
  assign bus.glyph_strobe = strobe_c;
  assign bus.char_addr    = ADDR_W'(char_row) * ADDR_W'(COLS) + ADDR_W'(col);
  // The lookup samples the code while strobed, so pass char_data straight through in LOOKUP.
  assign bus.glyph_code   = (state == LOOKUP) ? bus.char_data : code_q;
  assign bus.pixel        = pixel_q;
  assign bus.pixel_valid  = pixel_valid_q;
  assign bus.underrun     = underrun_q;

  always_ff @(posedge s or negedge rst_n) begin
    if (!rst_n) begin
      col           <= '0;
      char_row      <= '0;
      row_in_cell   <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      next_bits     <= '0;
      next_full     <= 1'b0;
      code_q        <= '0;
      pixel_q       <= 1'b0;
      pixel_valid_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      pixel_valid_q <= bus.de;

      if (bus.frame_start) begin
        char_row    <= '0;
        row_in_cell <= '0;
      end else if (pixel_valid_q && !bus.de) begin
        if (row_in_cell == GW'(GLYPH_H-1)) begin
          row_in_cell <= '0;
          char_row    <= (char_row == RW'(ROWS-1)) ? '0 : char_row + 1'b1;
        end else begin
          row_in_cell <= row_in_cell + 1'b1;
        end
      end

      if (bus.line_start) col <= '0;
      else if (state == WAIT && !next_full && col != CW'(COLS-1)) col <= col + 1'b1;

      if (state == LOOKUP) code_q <= bus.char_data;

      if (bus.de) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == 3'd0) begin
          if (next_full) begin
            shift     <= next_bits;
            next_full <= 1'b0;
            pixel_q   <= next_bits[7] ^ inv_next;
          end else begin
            shift      <= '0;
            pixel_q    <= 1'b0;
            underrun_q <= 1'b1;
          end
        end else begin
          pixel_q <= shift[~bit_cnt] ^ inv_cur;
        end
      end else begin
        pixel_q <= 1'b0;
        bit_cnt <= '0;
      end

      if (state == CAPTURE) begin
        next_bits <= bus.glyph_rows[{row_in_cell, 3'b000} +: 8];
        next_full <= 1'b1;
      end

      if (bus.line_start) begin
        next_full <= 1'b0;
        bit_cnt   <= '0;
      end
    end
  end

`ifdef TEXT_GLYPH_CURSOR_EN
  logic [5:0] frame_cnt;
  logic       next_cur, shift_cur;

  always_ff @(posedge s or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      next_cur  <= 1'b0;
      shift_cur <= 1'b0;
    end else begin
      if (bus.frame_start) frame_cnt <= frame_cnt + 1'b1;
      if (state == CAPTURE)
        next_cur <= (7'(col) == cursor_col) && (5'(char_row) == cursor_row);
      if (bus.de && bit_cnt == 3'd0) shift_cur <= next_full ? next_cur : 1'b0;
    end
  end

  assign inv_next = next_cur  & frame_cnt[5];
  assign inv_cur  = shift_cur & frame_cnt[5];
`else
  assign inv_next = 1'b0;
  assign inv_cur  = 1'b0;
`endif
endmodule
